bus_timer: RTL



---
 rtl/bus_timer_if.sv | 12 +
 rtl/bus_timer.sv | 113 +++++++++++
 2 files changed

// File: rtl/bus_timer_if.sv
// CPU-side control lines of the timer's bus port: write strobe, byte address and interrupt.
// The shared data bus stays a plain inout on the timer so tri-state resolution happens on one net.
interface bus_timer_if #(
  parameter int ADDR_BIT_WIDTH = 32
);
  logic                      wrtEn;
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      intr;

  modport master (output wrtEn, output addr, input intr);
  modport slave  (input wrtEn, input addr, output intr);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped tick timer: TCNT counts prescaled clock ticks, wraps at TLIM and
// latches RDY/OVF in TCTL; intr is the registered RDY & IE.
module bus_timer #(
  parameter int                        ADDR_BIT_WIDTH = 32,
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0] BASE_ADDR      = 32'hF0000020,
  parameter int                        CLKS_PER_TICK  = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  bus_timer_if.slave                bus,
  inout  wire  [DATA_BIT_WIDTH-1:0] dbus
);

  localparam int PSC_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLKS_PER_TICK - 1);

  logic [PSC_W-1:0]          psc_q, psc_d;
  logic [DATA_BIT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [DATA_BIT_WIDTH-1:0] tlim_q, tlim_d;
  logic                      rdy_q, rdy_d;
  logic                      ovf_q, ovf_d;
  logic                      ie_q, ie_d;
  logic                      intr_q, intr_d;

  logic                      sel;
  logic [1:0]                reg_off;
  logic                      wr_tcnt, wr_tlim, wr_tctl;
  logic                      tick, wrap_hit, wrap;
  logic                      rdy_keep, ovf_keep;
  logic [DATA_BIT_WIDTH-1:0] tctl_val, rd_data;

  assign reg_off = bus.addr[3:2];

  always_comb begin
    sel = (bus.addr[ADDR_BIT_WIDTH-1:4] == BASE_ADDR[ADDR_BIT_WIDTH-1:4])
          && bus.addr[28] && (bus.addr[1:0] == 2'b00) && (reg_off != 2'b11);
  end

  assign wr_tcnt = sel && bus.wrtEn && (reg_off == 2'd0);
  assign wr_tlim = sel && bus.wrtEn && (reg_off == 2'd1);
  assign wr_tctl = sel && bus.wrtEn && (reg_off == 2'd2);

  assign tick     = (psc_q == PSC_LAST);
  assign wrap_hit = tick && (tlim_q != '0) && (tcnt_q >= tlim_q - 1'b1);
  // A TCNT or TLIM write consumes the tick, so no wrap event can fire with it.
  assign wrap     = wrap_hit && !wr_tcnt && !wr_tlim;

  always_comb begin
    psc_d  = tick ? '0 : psc_q + 1'b1;
    tcnt_d = tcnt_q;
    tlim_d = tlim_q;
    ie_d   = ie_q;
    if (tick) begin
      tcnt_d = wrap_hit ? '0 : tcnt_q + 1'b1;
    end
    if (wr_tcnt) begin
      tcnt_d = dbus;
      psc_d  = '0;
    end
    if (wr_tlim) begin
      tlim_d = dbus;
      tcnt_d = '0;
      psc_d  = '0;
    end
    if (wr_tctl) begin
      ie_d = dbus[8];
    end
    // Write-0-to-clear first, then a wrap event overrides the clear of RDY.
    rdy_keep = rdy_q & ~(wr_tctl & ~dbus[0]);
    ovf_keep = ovf_q & ~(wr_tctl & ~dbus[2]);
    rdy_d    = rdy_keep | wrap;
    ovf_d    = ovf_keep | (wrap & rdy_keep);
    intr_d   = rdy_q & ie_q;
  end

  always_comb begin
    tctl_val    = '0;
    tctl_val[0] = rdy_q;
    tctl_val[2] = ovf_q;
    tctl_val[8] = ie_q;
    case (reg_off)
      2'd0:    rd_data = tcnt_q;
      2'd1:    rd_data = tlim_q;
      2'd2:    rd_data = tctl_val;
      default: rd_data = '0;
    endcase
  end

  assign dbus     = (sel && !bus.wrtEn) ? rd_data : 'z;
  assign bus.intr = intr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q  <= '0;
      tcnt_q <= '0;
      tlim_q <= '0;
      rdy_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ie_q   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      tcnt_q <= tcnt_d;
      tlim_q <= tlim_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
      ie_q   <= ie_d;
      intr_q <= intr_d;
    end
  end

endmodule
